// File: rtl/mult_mem_arbiter.sv
// Two-requester round-robin arbiter with burst locking in front of a single-port result memory.
// Grant is combinational; command registered (+1), read data returned at +2. Optional counters: MULT_MEM_ARB_STATS_EN.
module mult_mem_arbiter #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int MAXBURST = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EN_req0,
    input  logic                req0_we,
    input  logic                req0_lock,
    input  logic [LOGDEPTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]    req0_wdata,
    output logic                RDY_req0,
    output logic                VALID_req0,
    output logic [WIDTH-1:0]    req0_rdata,
    input  logic                EN_req1,
    input  logic                req1_we,
    input  logic                req1_lock,
    input  logic [LOGDEPTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]    req1_wdata,
    output logic                RDY_req1,
    output logic                VALID_req1,
    output logic [WIDTH-1:0]    req1_rdata,
    output logic                EN_mem,
    output logic                mem_we,
    output logic [LOGDEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
`ifdef MULT_MEM_ARB_STATS_EN
    output logic [15:0]         stat_grant0,
    output logic [15:0]         stat_grant1,
    output logic [15:0]         stat_stall0,
    output logic [15:0]         stat_stall1,
`endif
    input  logic [WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    localparam logic [7:0] MAXB = 8'(MAXBURST);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;
    logic                en_mem_q, en_mem_d;
    logic                mem_we_q, mem_we_d;
    logic [LOGDEPTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                tag_vld_q, tag_vld_d;
    logic                tag_own_q, tag_own_d;
    logic                valid0_q, valid0_d;
    logic                valid1_q, valid1_d;

    logic                gnt0, gnt1;
    logic                acc0, acc1, acc;
    logic                acc_we, acc_lock, other_en;
    logic [LOGDEPTH-1:0] acc_addr;
    logic [WIDTH-1:0]    acc_wdata;
    logic [7:0]          cnt_inc;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            ARB: begin
                if (EN_req0 && EN_req1) begin
                    gnt0 = !ptr_q;
                    gnt1 = ptr_q;
                end else begin
                    gnt0 = EN_req0;
                    gnt1 = EN_req1;
                end
            end
            LOCK0:   gnt0 = EN_req0;
            LOCK1:   gnt1 = EN_req1;
            default: ;
        endcase
    end

    // No grant while reset is asserted, so nothing is accepted in the reset cycle.
    assign RDY_req0 = gnt0 && !rst;
    assign RDY_req1 = gnt1 && !rst;
    assign acc0     = EN_req0 && RDY_req0;
    assign acc1     = EN_req1 && RDY_req1;
    assign acc      = acc0 || acc1;

    assign acc_we    = acc1 ? req1_we    : req0_we;
    assign acc_lock  = acc1 ? req1_lock  : req0_lock;
    assign acc_addr  = acc1 ? req1_addr  : req0_addr;
    assign acc_wdata = acc1 ? req1_wdata : req0_wdata;
    assign other_en  = acc1 ? EN_req0    : EN_req1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        cnt_inc     = 8'd1;
        if (state_q != ARB)
            cnt_inc = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
        if (acc) begin
            ptr_d = acc0;
            // The MAXBURST-th beat is still accepted; the lock breaks after it.
            if (!acc_lock || (cnt_inc >= MAXB && other_en)) begin
                state_d     = ARB;
                burst_cnt_d = 8'd0;
            end else begin
                state_d     = acc0 ? LOCK0 : LOCK1;
                burst_cnt_d = cnt_inc;
            end
        end else if (state_q == LOCK0 && !EN_req0) begin
            state_d     = ARB;
            ptr_d       = 1'b1;
            burst_cnt_d = 8'd0;
        end else if (state_q == LOCK1 && !EN_req1) begin
            state_d     = ARB;
            ptr_d       = 1'b0;
            burst_cnt_d = 8'd0;
        end
    end

    always_comb begin
        en_mem_d    = acc;
        mem_we_d    = acc && acc_we;
        mem_addr_d  = acc ? acc_addr  : mem_addr_q;
        mem_wdata_d = acc ? acc_wdata : mem_wdata_q;
        tag_vld_d   = acc && !acc_we;
        tag_own_d   = acc1;
        valid0_d    = tag_vld_q && !tag_own_q;
        valid1_d    = tag_vld_q && tag_own_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= 1'b0;
            burst_cnt_q <= 8'd0;
            en_mem_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_vld_q   <= 1'b0;
            tag_own_q   <= 1'b0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            en_mem_q    <= en_mem_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_vld_q   <= tag_vld_d;
            tag_own_q   <= tag_own_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
        end
    end

    assign EN_mem     = en_mem_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign VALID_req0 = valid0_q;
    assign VALID_req1 = valid1_q;
    // The macro output is already registered; it is only steered to its owner here.
    assign req0_rdata = valid0_q ? mem_rdata : '0;
    assign req1_rdata = valid1_q ? mem_rdata : '0;

`ifdef MULT_MEM_ARB_STATS_EN
    logic [15:0] grant0_q, grant0_d, grant1_q, grant1_d;
    logic [15:0] stall0_q, stall0_d, stall1_q, stall1_d;

    always_comb begin
        grant0_d = (acc0 && grant0_q != 16'hFFFF) ? grant0_q + 16'd1 : grant0_q;
        grant1_d = (acc1 && grant1_q != 16'hFFFF) ? grant1_q + 16'd1 : grant1_q;
        stall0_d = (EN_req0 && !RDY_req0 && stall0_q != 16'hFFFF) ? stall0_q + 16'd1 : stall0_q;
        stall1_d = (EN_req1 && !RDY_req1 && stall1_q != 16'hFFFF) ? stall1_q + 16'd1 : stall1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_q <= 16'd0;
            grant1_q <= 16'd0;
            stall0_q <= 16'd0;
            stall1_q <= 16'd0;
        end else begin
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            stall0_q <= stall0_d;
            stall1_q <= stall1_d;
        end
    end

    assign stat_grant0 = grant0_q;
    assign stat_grant1 = grant1_q;
    assign stat_stall0 = stall0_q;
    assign stat_stall1 = stall1_q;
`endif

endmodule

// File: tb/tb_mult_mem_arbiter.sv
// Scoreboard bench for mult_mem_arbiter: behavioural memory, per-requester read queues, grant log.
module tb_mult_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EN_req0 = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
    logic [5:0]  req0_addr = '0;
    logic [31:0] req0_wdata = '0;
    logic        EN_req1 = 1'b0, req1_we = 1'b0, req1_lock = 1'b0;
    logic [5:0]  req1_addr = '0;
    logic [31:0] req1_wdata = '0;
    logic        RDY_req0, VALID_req0, RDY_req1, VALID_req1;
    logic [31:0] req0_rdata, req1_rdata;
    logic        EN_mem, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    mult_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .EN_req0(EN_req0), .req0_we(req0_we), .req0_lock(req0_lock), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .RDY_req0(RDY_req0), .VALID_req0(VALID_req0), .req0_rdata(req0_rdata),
        .EN_req1(EN_req1), .req1_we(req1_we), .req1_lock(req1_lock), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .RDY_req1(RDY_req1), .VALID_req1(VALID_req1), .req1_rdata(req1_rdata),
        .EN_mem(EN_mem), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] d; } rd_t;
    typedef struct { int cyc; int id; } gnt_t;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    bit          mon_on  = 0;
    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    rd_t         rq0[$], rq1[$];
    gnt_t        glog[$];
    logic        exp_en = 0, exp_we = 0;
    logic [5:0]  exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (EN_mem) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("en_mem", 32'(EN_mem), 32'(exp_en));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", mem_wdata, exp_wdata);
            if (rq0.size() > 0 && rq0[0].due == cyc) begin
                chk("valid0", 32'(VALID_req0), 1);
                chk("rdata0", req0_rdata, rq0[0].d);
                rq0.delete(0);
            end else chk("valid0_idle", 32'(VALID_req0), 0);
            if (rq1.size() > 0 && rq1[0].due == cyc) begin
                chk("valid1", 32'(VALID_req1), 1);
                chk("rdata1", req1_rdata, rq1[0].d);
                rq1.delete(0);
            end else chk("valid1_idle", 32'(VALID_req1), 0);
            chk("rdy_onehot", 32'(RDY_req0 & RDY_req1), 0);
            chk("rdy_needs_en", 32'((RDY_req0 & ~EN_req0) | (RDY_req1 & ~EN_req1)), 0);
        end
        if (rst) begin
            exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
            rq0.delete(); rq1.delete();
        end else if ((EN_req0 && RDY_req0) || (EN_req1 && RDY_req1)) begin
            int          n;
            logic        we;
            logic [5:0]  a;
            logic [31:0] d;
            n  = (EN_req0 && RDY_req0) ? 0 : 1;
            we = n ? req1_we : req0_we;
            a  = n ? req1_addr : req0_addr;
            d  = n ? req1_wdata : req0_wdata;
            exp_en = 1; exp_we = we; exp_addr = a; exp_wdata = d;
            glog.push_back('{cyc, n});
            if (we) ref_mem[a] = d;
            else if (n == 0) rq0.push_back('{cyc + 2, ref_mem[a]});
            else rq1.push_back('{cyc + 2, ref_mem[a]});
        end else begin
            exp_en = 0; exp_we = 0;
        end
    end

    task automatic beat(input int n, input logic we, input logic lk, input logic [5:0] a, input logic [31:0] d);
        int waited = 0;
        if (n == 0) begin
            EN_req0 = 1; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
        end else begin
            EN_req1 = 1; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
        end
        forever begin
            @(negedge clk);
            if ((n == 0) ? RDY_req0 : RDY_req1) break;
            waited++;
            if (waited > 300) begin
                chk("grant_timeout", 32'(waited), 300);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if (n == 0) begin EN_req0 = 0; req0_lock = 0; end
        else        begin EN_req1 = 0; req1_lock = 0; end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy0"}, 32'(RDY_req0), 0);
        chk({tag, "_rdy1"}, 32'(RDY_req1), 0);
        chk({tag, "_valid0"}, 32'(VALID_req0), 0);
        chk({tag, "_valid1"}, 32'(VALID_req1), 0);
        chk({tag, "_en_mem"}, 32'(EN_mem), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata0"}, req0_rdata, 0);
        chk({tag, "_rdata1"}, req1_rdata, 0);
    endtask

    initial begin
        int zeros;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_on = 1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Both requesting, no lock: strict alternation from requester 0.
        glog.delete();
        fork
            begin for (int i = 0; i < 8; i++) beat(0, 1, 0, 6'(16 + i), 32'hA0 + i); idle(0); end
            begin for (int i = 0; i < 8; i++) beat(1, 1, 0, 6'(32 + i), 32'hB0 + i); idle(1); end
        join
        chk("alt_count", 32'(glog.size()), 16);
        for (int i = 0; i < glog.size(); i++) begin
            chk("alt_id", 32'(glog[i].id), 32'(i % 2));
            chk("alt_cyc", 32'(glog[i].cyc - glog[0].cyc), 32'(i));
        end

        // Full 64-beat locked write burst, requester 1 idle.
        glog.delete();
        for (int i = 0; i < 64; i++) beat(0, 1, 1, 6'(i), 32'(i));
        idle(0);
        zeros = 0;
        foreach (glog[i]) if (glog[i].id == 0) zeros++;
        chk("burst64_grants", 32'(zeros), 64);
        chk("burst64_span", 32'(glog[63].cyc - glog[0].cyc), 63);
        repeat (2) @(posedge clk); #1;

        // Locked burst against a waiting requester 1: broken after MAXBURST beats.
        beat(1, 0, 0, 6'd3, 0);
        idle(1);
        glog.delete();
        fork
            begin for (int i = 0; i < 70; i++) beat(0, 1, 1, 6'(i), 32'h1000 + i); idle(0); end
            begin beat(1, 0, 0, 6'd7, 0); idle(1); end
        join
        zeros = 0;
        for (int i = 0; i < 64; i++) if (glog[i].id == 0) zeros++;
        chk("maxburst_owner_beats", 32'(zeros), 64);
        chk("maxburst_span", 32'(glog[63].cyc - glog[0].cyc), 63);
        chk("maxburst_next_id", 32'(glog[64].id), 1);
        chk("maxburst_next_cyc", 32'(glog[64].cyc - glog[63].cyc), 1);
        repeat (2) @(posedge clk); #1;

        // Write then immediate read of the same address by the other requester.
        beat(0, 1, 0, 6'd5, 32'hDEADBEEF); idle(0);
        beat(1, 0, 0, 6'd5, 0); idle(1);
        repeat (4) @(posedge clk); #1;

        // Back-to-back reads from different requesters.
        beat(0, 1, 0, 6'd1, 32'h11); idle(0);
        beat(1, 1, 0, 6'd2, 32'h22); idle(1);
        beat(0, 0, 0, 6'd1, 0); idle(0);
        beat(1, 0, 0, 6'd2, 0); idle(1);
        repeat (4) @(posedge clk); #1;

        // Reset during a locked burst, just after a read beat.
        for (int i = 0; i < 9; i++) beat(0, 1, 1, 6'(40 + i), 32'h600 + i);
        beat(0, 0, 1, 6'd16, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        idle(0);
        @(negedge clk);
        check_reset_outputs("midburst_rst");
        @(posedge clk); #1;
        glog.delete();
        fork
            begin beat(0, 1, 0, 6'd50, 32'h50); idle(0); end
            begin beat(1, 1, 0, 6'd51, 32'h51); idle(1); end
        join
        chk("post_rst_ptr", 32'(glog[0].id), 0);
        chk("post_rst_second", 32'(glog[1].id), 1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rq0_drain", 32'(rq0.size()), 0);
        chk("rq1_drain", 32'(rq1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
